vid_timing: RTL and testbench

VID_TIMING -- requirements
Module: vid_timing

---
 rtl/vid_timing_if.sv | 25 ++
 rtl/vid_timing.sv | 97 +++++++++
 tb/tb_vid_timing.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/vid_timing_if.sv
// vid_timing_if: pixel strobe, mode and light pen inputs plus raster timing outputs
interface vid_timing_if;
   logic       PIXEN;
   logic       NTSC;
   logic       LP;
   logic       LPRD;
   logic [8:0] HCNT;
   logic [8:0] VCNT;
   logic       HSYNCL;
   logic       VSYNCL;
   logic       BLANK;
   logic       LINEST;
   logic       FRAMEST;
   logic [8:0] LPH;
   logic [8:0] LPV;
   logic       LPVALID;
   modport master (
      output PIXEN, NTSC, LP, LPRD,
      input  HCNT, VCNT, HSYNCL, VSYNCL, BLANK, LINEST, FRAMEST, LPH, LPV, LPVALID
   );
   modport slave (
      input  PIXEN, NTSC, LP, LPRD,
      output HCNT, VCNT, HSYNCL, VSYNCL, BLANK, LINEST, FRAMEST, LPH, LPV, LPVALID
   );
endinterface

// File: rtl/vid_timing.sv
// vid_timing: raster counters, registered sync/blank/start decodes and light pen latch
module vid_timing #(
   parameter int HTOT      = 384,
   parameter int HDISP     = 256,
   parameter int HSS       = 300,
   parameter int HSW       = 28,
   parameter int VDISP     = 200,
   parameter int VTOT_PAL  = 312,
   parameter int VTOT_NTSC = 262,
   parameter int VSS_PAL   = 260,
   parameter int VSS_NTSC  = 230,
   parameter int VSW       = 3
) (
   input logic         MCK,
   input logic         RESET,
   vid_timing_if.slave bus
);
   logic [8:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d, lph_q, lph_d, lpv_q, lpv_d, vtot_m1, vss;
   logic       ntsc_q, ntsc_d, hsyncl_q, hsyncl_d, vsyncl_q, vsyncl_d, blank_q, blank_d;
   logic       linest_q, linest_d, framest_q, framest_d, lpvalid_q, lpvalid_d;
   logic       lp_s1_q, lp_s1_d, lp_s2_q, lp_s2_d, lp_prev_q, lp_prev_d;
   logic       hwrap, vwrap, det, cap;

   // counter advance and decodes from the next-state counts so outputs line up with HCNT/VCNT
   always_comb begin
      hwrap     = bus.PIXEN && hcnt_q == 9'(HTOT - 1);
      vtot_m1   = ntsc_q ? 9'(VTOT_NTSC - 1) : 9'(VTOT_PAL - 1);
      vwrap     = hwrap && vcnt_q == vtot_m1;
      hcnt_d    = hwrap ? '0 : bus.PIXEN ? hcnt_q + 9'd1 : hcnt_q;
      vcnt_d    = vwrap ? '0 : hwrap ? vcnt_q + 9'd1 : vcnt_q;
      ntsc_d    = vwrap ? bus.NTSC : ntsc_q;
      vss       = ntsc_d ? 9'(VSS_NTSC) : 9'(VSS_PAL);
      hsyncl_d  = !(hcnt_d >= 9'(HSS) && hcnt_d <= 9'(HSS + HSW - 1));
      vsyncl_d  = !(vcnt_d >= vss && vcnt_d <= vss + 9'(VSW - 1));
      blank_d   = hcnt_d >= 9'(HDISP) || vcnt_d >= 9'(VDISP);
      linest_d  = hwrap;
      framest_d = vwrap;
   end

   // light pen: two-flop synchroniser, rising-edge detect; a read strobe re-arms the latch in the same cycle
   always_comb begin
      lp_s1_d   = bus.LP;
      lp_s2_d   = lp_s1_q;
      lp_prev_d = lp_s2_q;
      det       = lp_s2_q && !lp_prev_q;
      cap       = det && (!lpvalid_q || bus.LPRD);
      lph_d     = cap ? hcnt_q : lph_q;
      lpv_d     = cap ? vcnt_q : lpv_q;
      lpvalid_d = cap || (lpvalid_q && !bus.LPRD);
   end

   // state register with asynchronous reset to the idle raster position
   always_ff @(posedge MCK or posedge RESET) begin
      if (RESET) begin
         hcnt_q    <= '0;
         vcnt_q    <= '0;
         ntsc_q    <= 1'b0;
         hsyncl_q  <= 1'b1;
         vsyncl_q  <= 1'b1;
         blank_q   <= 1'b0;
         linest_q  <= 1'b0;
         framest_q <= 1'b0;
         lp_s1_q   <= 1'b0;
         lp_s2_q   <= 1'b0;
         lp_prev_q <= 1'b0;
         lph_q     <= '0;
         lpv_q     <= '0;
         lpvalid_q <= 1'b0;
      end else begin
         hcnt_q    <= hcnt_d;
         vcnt_q    <= vcnt_d;
         ntsc_q    <= ntsc_d;
         hsyncl_q  <= hsyncl_d;
         vsyncl_q  <= vsyncl_d;
         blank_q   <= blank_d;
         linest_q  <= linest_d;
         framest_q <= framest_d;
         lp_s1_q   <= lp_s1_d;
         lp_s2_q   <= lp_s2_d;
         lp_prev_q <= lp_prev_d;
         lph_q     <= lph_d;
         lpv_q     <= lpv_d;
         lpvalid_q <= lpvalid_d;
      end
   end

   assign bus.HCNT    = hcnt_q;
   assign bus.VCNT    = vcnt_q;
   assign bus.HSYNCL  = hsyncl_q;
   assign bus.VSYNCL  = vsyncl_q;
   assign bus.BLANK   = blank_q;
   assign bus.LINEST  = linest_q;
   assign bus.FRAMEST = framest_q;
   assign bus.LPH     = lph_q;
   assign bus.LPV     = lpv_q;
   assign bus.LPVALID = lpvalid_q;
endmodule

// File: tb/tb_vid_timing.sv
// tb_vid_timing: random pixel cadence against a frame-position model, plus directed light pen and reset steps
module tb_vid_timing;
   localparam int HTOT = 384, HDISP = 256, HSS = 300, HSW = 28, VDISP = 20;
   localparam int VTOT_PAL = 32, VTOT_NTSC = 28, VSS_PAL = 26, VSS_NTSC = 23, VSW = 3;

   logic MCK = 1'b0;
   logic RESET = 1'b0;
   vid_timing_if bus ();

   vid_timing #(
      .HTOT(HTOT), .HDISP(HDISP), .HSS(HSS), .HSW(HSW), .VDISP(VDISP),
      .VTOT_PAL(VTOT_PAL), .VTOT_NTSC(VTOT_NTSC), .VSS_PAL(VSS_PAL), .VSS_NTSC(VSS_NTSC), .VSW(VSW)
   ) dut (
      .MCK(MCK),
      .RESET(RESET),
      .bus(bus)
   );

   always #5 MCK = ~MCK;

   int checks = 0, fails = 0;
   int p = 0, mode = 0;
   bit exp_ls, exp_fs;
   int nf = 0, pix_since = 0, nvs = 0, fvs = -1, nhs = 0, fhs = -1, nls = 0;
   int flen[4], vsl[4], vsf[4];

   function automatic int vtot_of(input int m);
      return m != 0 ? VTOT_NTSC : VTOT_PAL;
   endfunction

   task automatic ck(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic chk_raster();
      int h, v, vs;
      h  = p % HTOT;
      v  = p / HTOT;
      vs = mode != 0 ? VSS_NTSC : VSS_PAL;
      ck("hcnt", bus.HCNT, h);
      ck("vcnt", bus.VCNT, v);
      ck("hsyncl", bus.HSYNCL, !(h >= HSS && h < HSS + HSW));
      ck("vsyncl", bus.VSYNCL, !(v >= vs && v < vs + VSW));
      ck("blank", bus.BLANK, h >= HDISP || v >= VDISP);
      ck("linest", bus.LINEST, exp_ls);
      ck("framest", bus.FRAMEST, exp_fs);
   endtask

   task automatic chk_reset(input string tag);
      ck({tag, "_hcnt"}, bus.HCNT, 0);
      ck({tag, "_vcnt"}, bus.VCNT, 0);
      ck({tag, "_hsyncl"}, bus.HSYNCL, 1);
      ck({tag, "_vsyncl"}, bus.VSYNCL, 1);
      ck({tag, "_blank"}, bus.BLANK, 0);
      ck({tag, "_linest"}, bus.LINEST, 0);
      ck({tag, "_framest"}, bus.FRAMEST, 0);
      ck({tag, "_lph"}, bus.LPH, 0);
      ck({tag, "_lpv"}, bus.LPV, 0);
      ck({tag, "_lpvalid"}, bus.LPVALID, 0);
   endtask

   task automatic step(input bit pix);
      bus.PIXEN = pix;
      @(posedge MCK);
      #1;
      bus.PIXEN = 1'b0;
      exp_ls = 1'b0;
      exp_fs = 1'b0;
      if (pix && !RESET) begin
         p++;
         pix_since++;
         if (p == HTOT * vtot_of(mode)) begin
            p = 0;
            mode = bus.NTSC ? 1 : 0;
         end
         exp_ls = (p % HTOT) == 0;
         exp_fs = p == 0;
      end
      if (bus.FRAMEST) begin
         if (nf < 4) begin
            flen[nf] = pix_since;
            vsl[nf]  = nvs;
            vsf[nf]  = fvs;
         end
         nf++;
         pix_since = 0;
         nvs = 0;
         fvs = -1;
      end
      if (bus.LINEST && !bus.VSYNCL) begin
         nvs++;
         if (fvs < 0) fvs = int'(bus.VCNT);
      end
      if (pix && !bus.HSYNCL) begin
         nhs++;
         if (fhs < 0) fhs = int'(bus.HCNT);
      end
      if (bus.LINEST) nls++;
      chk_raster();
   endtask

   task automatic run_to(input int tv, input int th);
      int n = 0;
      while (!(p / HTOT == tv && p % HTOT == th) && n < 30000) begin
         step($urandom_range(15) != 0);
         n++;
      end
      ck("run_to_v", bus.VCNT, tv);
      ck("run_to_h", bus.HCNT, th);
   endtask

   task automatic run_frames(input int t);
      int n = 0;
      while (nf < t && n < 40000) begin
         step($urandom_range(15) != 0);
         n++;
      end
      ck("frames_reached", nf, t);
   endtask

   initial begin
      bus.PIXEN = 1'b0;
      bus.NTSC  = 1'b0;
      bus.LP    = 1'b0;
      bus.LPRD  = 1'b0;
      foreach (flen[i]) begin
         flen[i] = 0;
         vsl[i]  = 0;
         vsf[i]  = 0;
      end
      #1 RESET = 1'b1;
      #1 chk_reset("rst0");
      step(0);
      step(0);
      RESET = 1'b0;
      nls = 0; nhs = 0; fhs = -1; pix_since = 0;

      for (int i = 0; i < HTOT; i++) begin
         step(0);
         step(0);
         step(1);
      end
      ck("line_hcnt", bus.HCNT, 0);
      ck("line_vcnt", bus.VCNT, 1);
      ck("line_linest_pulses", nls, 1);
      ck("line_hsync_strobes", nhs, HSW);
      ck("line_hsync_first", fhs, HSS);

      run_frames(1);
      ck("pal_frame_len", flen[0], HTOT * VTOT_PAL);
      ck("pal_vsync_lines", vsl[0], VSW);
      ck("pal_vsync_first", vsf[0], VSS_PAL);

      run_to(10, 0);
      bus.NTSC = 1'b1;
      run_frames(2);
      ck("switch_frame_len", flen[1], HTOT * VTOT_PAL);
      ck("switch_vsync_first", vsf[1], VSS_PAL);
      run_frames(3);
      ck("ntsc_frame_len", flen[2], HTOT * VTOT_NTSC);
      ck("ntsc_vsync_lines", vsl[2], VSW);
      ck("ntsc_vsync_first", vsf[2], VSS_NTSC);

      run_to(12, 50);
      bus.LP = 1'b1;
      step(0);
      step(0);
      step(0);
      ck("lp1_lph", bus.LPH, 50);
      ck("lp1_lpv", bus.LPV, 12);
      ck("lp1_valid", bus.LPVALID, 1);
      bus.LP = 1'b0;
      step(0);
      step(0);
      run_to(12, 60);
      bus.LP = 1'b1;
      step(0);
      step(0);
      step(0);
      bus.LP = 1'b0;
      step(0);
      step(0);
      ck("lp2_lph_hold", bus.LPH, 50);
      ck("lp2_lpv_hold", bus.LPV, 12);
      ck("lp2_valid", bus.LPVALID, 1);

      run_to(12, 80);
      bus.LP = 1'b1;
      step(0);
      step(0);
      bus.LPRD = 1'b1;
      step(0);
      bus.LPRD = 1'b0;
      ck("lp3_lph", bus.LPH, 80);
      ck("lp3_lpv", bus.LPV, 12);
      ck("lp3_valid", bus.LPVALID, 1);
      bus.LP = 1'b0;
      step(0);
      step(0);
      bus.LPRD = 1'b1;
      step(0);
      bus.LPRD = 1'b0;
      ck("lprd_valid", bus.LPVALID, 0);
      ck("lprd_lph_hold", bus.LPH, 80);

      run_to(24, 200);
      bus.LP = 1'b1;
      step(0);
      #3 RESET = 1'b1;
      p = 0;
      mode = 0;
      #1 chk_reset("arst");
      bus.LP = 1'b0;
      step(0);
      step(0);
      RESET = 1'b0;
      step(0);
      step(0);
      step(0);
      ck("post_rst_lpvalid", bus.LPVALID, 0);
      step(1);
      ck("post_rst_hcnt", bus.HCNT, 1);
      ck("post_rst_vcnt", bus.VCNT, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
